// File: rtl/ksa_pkg.sv
// ksa_pkg -- shared types and constants for the RC4 key-scheduling engine.
//   state_e   : FSM state encoding used by ksa
//   KEY_BYTES : number of key bytes cycled through by the key counter
//   S_SIZE    : number of entries in the external S memory
//   key_byte  : selects one byte of the 24-bit key by counter value
package ksa_pkg;

   localparam int KEY_BYTES = 3;
   localparam int S_SIZE    = 256;

   typedef enum logic [2:0] {
      IDLE,
      RD_I,
      WT_I,
      RD_J,
      WT_J,
      WR_I,
      WR_J
   } state_e;

   // Byte 0 is the most significant byte of the key word.
   function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = k[23:16];
         2'd1:    b = k[15:8];
         default: b = k[7:0];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/ksa.sv
// ksa -- RC4 key-scheduling pass over an externally initialised 256-byte
// S memory. One swap iteration takes six cycles: read S[i], wait, read S[j],
// wait, write S[i]<=S[j], write S[j]<=S[i].
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   en      : start request, honoured only while rdy=1
//   rdy     : idle and able to accept en
//   key     : 24-bit key, latched when a run is accepted
//   addr    : S-memory address
//   rddata  : S-memory read data, valid the cycle after addr (wren=0)
//   wrdata  : S-memory write data (0 outside write states)
//   wren    : S-memory write enable
module ksa
   import ksa_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  addr,
   input  logic [7:0]  rddata,
   output logic [7:0]  wrdata,
   output logic        wren
);

   state_e      state_q, state_d;
   logic [7:0]  i_q, i_d;
   logic [7:0]  j_q, j_d;
   logic [1:0]  kidx_q, kidx_d;
   logic [7:0]  si_q, si_d;
   logic [7:0]  sj_q, sj_d;
   logic [23:0] key_q, key_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         kidx_q  <= '0;
         si_q    <= '0;
         sj_q    <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         i_q     <= i_d;
         j_q     <= j_d;
         kidx_q  <= kidx_d;
         si_q    <= si_d;
         sj_q    <= sj_d;
         key_q   <= key_d;
      end
   end

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      kidx_d  = kidx_q;
      si_d    = si_q;
      sj_d    = sj_q;
      key_d   = key_q;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d = RD_I;
               i_d     = '0;
               j_d     = '0;
               kidx_d  = '0;
               key_d   = key;
            end
         end
         RD_I: state_d = WT_I;
         WT_I: begin
            // 8-bit sum wraps modulo 256 by construction.
            si_d    = rddata;
            j_d     = j_q + rddata + key_byte(key_q, kidx_q);
            state_d = RD_J;
         end
         RD_J: state_d = WT_J;
         WT_J: begin
            sj_d    = rddata;
            state_d = WR_I;
         end
         WR_I: state_d = WR_J;
         WR_J: begin
            if (i_q == 8'(S_SIZE - 1)) begin
               state_d = IDLE;
            end else begin
               i_d     = i_q + 8'd1;
               // Cycles 0,1,2 so i mod 3 needs no divider.
               kidx_d  = (kidx_q == 2'(KEY_BYTES - 1)) ? 2'd0 : kidx_q + 2'd1;
               state_d = RD_I;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Moore outputs: decoded from registered state only. When i=j the two
   // writes hit the same address with si=sj, so no special case is needed.
   always_comb begin
      rdy    = 1'b0;
      wren   = 1'b0;
      addr   = '0;
      wrdata = '0;
      case (state_q)
         IDLE: rdy = 1'b1;
         RD_I, WT_I: addr = i_q;
         RD_J, WT_J: addr = j_q;
         WR_I: begin
            addr   = i_q;
            wrdata = sj_q;
            wren   = 1'b1;
         end
         WR_J: begin
            addr   = j_q;
            wrdata = si_q;
            wren   = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ksa.sv
// tb_ksa -- directed self-checking bench for ksa with a behavioural
// synchronous S memory and a software RC4 KSA reference.
module tb_ksa;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic        rdy;
   logic [23:0] key;
   logic [7:0]  addr;
   logic [7:0]  rddata;
   logic [7:0]  wrdata;
   logic        wren;

   logic        init_req;
   logic [7:0]  mem  [256];
   logic [7:0]  gold [256];

   logic [7:0]  tr_addr [1600];
   logic        tr_wren [1600];
   logic [7:0]  tr_wd   [1600];
   int          n_lo, n_wr;
   bit          timed_out;

   int tests = 0;
   int fails = 0;

   ksa dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .rdy    (rdy),
      .key    (key),
      .addr   (addr),
      .rddata (rddata),
      .wrdata (wrdata),
      .wren   (wren)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous memory: read data appears the cycle after the address.
   always @(posedge clk) begin
      if (init_req) begin
         for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
      end else if (wren) begin
         mem[addr] <= wrdata;
      end
      rddata <= mem[addr];
   end

   task automatic init_s();
      init_req = 1'b1;
      @(negedge clk);
      init_req = 1'b0;
   endtask

   task automatic gold_ksa(input logic [23:0] k);
      logic [7:0] s [256];
      logic [7:0] j, t, kb;
      for (int n = 0; n < 256; n++) s[n] = 8'(n);
      j = 8'd0;
      for (int n = 0; n < 256; n++) begin
         case (n % 3)
            0:       kb = k[23:16];
            1:       kb = k[15:8];
            default: kb = k[7:0];
         endcase
         j = j + s[n] + kb;
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      for (int n = 0; n < 256; n++) gold[n] = s[n];
   endtask

   task automatic check_s(input string name);
      int bad = 0;
      int first = -1;
      for (int n = 0; n < 256; n++) begin
         if (mem[n] !== gold[n]) begin
            bad++;
            if (first < 0) first = n;
         end
      end
      tests++;
      if (bad != 0) begin
         fails++;
         $display("FAIL %s: %0d entries differ, first S[%0d] got %h want %h",
                  name, bad, first, mem[first], gold[first]);
      end
   endtask

   // Start a run and trace outputs each cycle until rdy returns. Optional
   // mid-run en/key injection, mid-run reset, or en held high throughout.
   task automatic do_run(input logic [23:0] k, input int inj_cyc, input logic [23:0] inj_key,
                         input int rst_cyc, input bit hold_en);
      n_lo = 0; n_wr = 0; timed_out = 0;
      key = k; en = 1'b1;
      @(negedge clk);
      if (!hold_en) en = 1'b0;
      while (rdy == 1'b0) begin
         if (n_lo >= 2000) begin timed_out = 1; break; end
         if (n_lo < 1600) begin
            tr_addr[n_lo] = addr; tr_wren[n_lo] = wren; tr_wd[n_lo] = wrdata;
         end
         if (wren) n_wr++;
         if (n_lo == inj_cyc) begin en = 1'b1; key = inj_key; end
         if (n_lo == inj_cyc + 1) en = hold_en;
         if (n_lo == rst_cyc) begin
            rst_n = 1'b0;
            #1;
            tests++;
            if (rdy !== 1'b1 || wren !== 1'b0) begin
               fails++; $display("FAIL abort_immediate: rdy=%b wren=%b want rdy=1 wren=0", rdy, wren);
            end
            @(negedge clk);
            tests++;
            if (wren !== 1'b0 || addr !== 8'h00) begin
               fails++; $display("FAIL abort_held: wren=%b addr=%h want 0/00", wren, addr);
            end
            en = 1'b0;
            rst_n = 1'b1;
            break;
         end
         n_lo++;
         @(negedge clk);
      end
      if (timed_out) begin
         tests++; fails++;
         $display("FAIL run_timeout: rdy still 0 after %0d cycles", n_lo);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 1'b1; key = 24'hFFFFFF; init_req = 1'b0;
      @(negedge clk);
      tests++; if (rdy !== 1'b1)   begin fails++; $display("FAIL rst_rdy: got %b want 1", rdy); end
      tests++; if (wren !== 1'b0)  begin fails++; $display("FAIL rst_wren: got %b want 0", wren); end
      tests++; if (addr !== 8'h00) begin fails++; $display("FAIL rst_addr: got %h want 00", addr); end
      tests++; if (wrdata !== 8'h00) begin fails++; $display("FAIL rst_wrdata: got %h want 00", wrdata); end
      rst_n = 1'b1;
      #1;
      tests++;
      if (rdy !== 1'b1 || wren !== 1'b0 || addr !== 8'h00 || wrdata !== 8'h00) begin
         fails++;
         $display("FAIL post_release: rdy=%b wren=%b addr=%h wrdata=%h want 1/0/00/00", rdy, wren, addr, wrdata);
      end
      en = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_key_zero();
      init_s();
      gold_ksa(24'h000000);
      do_run(24'h000000, -1, 24'h0, -1, 1'b0);
      for (int c = 0; c < 4; c++) begin
         tests++;
         if (tr_addr[c] !== 8'h00 || tr_wren[c] !== 1'b0) begin
            fails++; $display("FAIL k0_read%0d: addr=%h wren=%b want 00/0", c, tr_addr[c], tr_wren[c]);
         end
      end
      for (int c = 4; c < 6; c++) begin
         tests++;
         if (tr_addr[c] !== 8'h00 || tr_wren[c] !== 1'b1 || tr_wd[c] !== 8'h00) begin
            fails++; $display("FAIL k0_write%0d: addr=%h wren=%b wd=%h want 00/1/00", c, tr_addr[c], tr_wren[c], tr_wd[c]);
         end
      end
      tests++; if (tr_addr[8] !== 8'h01) begin fails++; $display("FAIL k0_iter1_j: got %h want 01", tr_addr[8]); end
      tests++; if (n_lo != 1536) begin fails++; $display("FAIL latency_busy: got %0d want 1536", n_lo); end
      tests++; if (n_wr != 512)  begin fails++; $display("FAIL latency_writes: got %0d want 512", n_wr); end
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL latency_rdy: got %b want 1", rdy); end
      check_s("k0_final_s");
   endtask

   task automatic test_key_033c();
      init_s();
      gold_ksa(24'h00033C);
      do_run(24'h00033C, -1, 24'h0, -1, 1'b0);
      tests++; if (tr_addr[8] !== 8'h04) begin fails++; $display("FAIL k1_iter1_j: got %h want 04", tr_addr[8]); end
      tests++;
      if (tr_addr[10] !== 8'h01 || tr_wd[10] !== 8'h04 || tr_wren[10] !== 1'b1) begin
         fails++; $display("FAIL k1_wr_i: addr=%h wd=%h wren=%b want 01/04/1", tr_addr[10], tr_wd[10], tr_wren[10]);
      end
      tests++;
      if (tr_addr[11] !== 8'h04 || tr_wd[11] !== 8'h01 || tr_wren[11] !== 1'b1) begin
         fails++; $display("FAIL k1_wr_j: addr=%h wd=%h wren=%b want 04/01/1", tr_addr[11], tr_wd[11], tr_wren[11]);
      end
      tests++; if (tr_addr[14] !== 8'h42) begin fails++; $display("FAIL k1_iter2_j: got %h want 42", tr_addr[14]); end
      check_s("k1_final_s");
   endtask

   task automatic test_midrun_ignore();
      init_s();
      gold_ksa(24'h00033C);
      do_run(24'h00033C, 50, 24'hA5F00F, -1, 1'b0);
      tests++; if (n_lo != 1536) begin fails++; $display("FAIL midrun_busy: got %0d want 1536", n_lo); end
      tests++; if (n_wr != 512)  begin fails++; $display("FAIL midrun_writes: got %0d want 512", n_wr); end
      check_s("midrun_final_s");
   endtask

   task automatic test_reset_midrun();
      init_s();
      do_run(24'h00033C, -1, 24'h0, 602, 1'b0);
      @(negedge clk);
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL abort_idle: rdy=%b want 1", rdy); end
      init_s();
      gold_ksa(24'h00033C);
      do_run(24'h00033C, -1, 24'h0, -1, 1'b0);
      tests++; if (tr_addr[0] !== 8'h00) begin fails++; $display("FAIL restart_i0: got %h want 00", tr_addr[0]); end
      check_s("restart_final_s");
   endtask

   task automatic test_back_to_back();
      init_s();
      do_run(24'h000000, -1, 24'h0, -1, 1'b1);
      tests++; if (n_lo != 1536) begin fails++; $display("FAIL b2b_busy: got %0d want 1536", n_lo); end
      @(negedge clk);
      tests++; if (rdy !== 1'b0) begin fails++; $display("FAIL b2b_restart: rdy=%b want 0", rdy); end
      en = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      tests++; if (rdy !== 1'b1) begin fails++; $display("FAIL b2b_abort: rdy=%b want 1", rdy); end
   endtask

   initial begin
      test_reset();
      test_key_zero();
      test_key_033c();
      test_midrun_ignore();
      test_reset_midrun();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
